// File: rtl/s3g_tx_arbiter.sv
// s3g_tx_arbiter
// Shares one byte-level UART transmitter between two frame sources. Whole
// frames are granted round-robin. Each granted payload goes out as an S3G
// frame: sync 0xD5, length, payload bytes, then a Dallas/Maxim CRC-8 of the
// payload.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   reqN_valid/len/data   frame request from port N (0 = reply, 1 = irq report)
//   reqN_ack              one-cycle pulse, request N consumed
//   tx_data, tx_wr        byte and write strobe to the UART
//   tx_done               UART finished the previous byte
//   busy                  frame in progress (grant .. CRC byte's tx_done)
//   grant                 port currently / last granted
//   err_len               one-cycle pulse, illegal-length request dropped
//
// state  | meaning
// IDLE   | arbitrate; grant cycle latches the request
// SYNC   | write 0xD5
// LEN    | write payload length
// DATA   | write top payload byte, fold into CRC, shift
// CRC    | write CRC byte
// WAIT   | hold until tx_done, then go to ret_q
module s3g_tx_arbiter #(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [3:0]           req0_len,
  input  logic [8*MAX_LEN-1:0] req0_data,
  output logic                 req0_ack,
  input  logic                 req1_valid,
  input  logic [3:0]           req1_len,
  input  logic [8*MAX_LEN-1:0] req1_data,
  output logic                 req1_ack,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 grant,
  output logic                 err_len
);

  localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN,
    S_DATA,
    S_CRC,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  state_t               ret_q, ret_d;
  logic [8*MAX_LEN-1:0] shift_q, shift_d;
  logic [3:0]           len_q, len_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           crc_q, crc_d;
  logic                 last_q, last_d;
  logic                 grant_q, grant_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 err_q, err_d;

  logic                 v0, v1, sel1;
  logic [3:0]           sel_len;
  logic [8*MAX_LEN-1:0] sel_data;
  logic [7:0]           top_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  // A port whose ack is on the wire this cycle is masked, so a requester that
  // drops valid in reaction to the ack is never granted twice (matters after an
  // err_len drop, where the FSM is back in IDLE in the ack cycle).
  assign v0   = req0_valid & ~ack0_q;
  assign v1   = req1_valid & ~ack1_q;
  // On a tie the port that was not granted last wins.
  assign sel1 = v1 & (~v0 | ~last_q);

  assign sel_len  = sel1 ? req1_len  : req0_len;
  assign sel_data = sel1 ? req1_data : req0_data;
  assign top_byte = shift_q[8*MAX_LEN-1 -: 8];

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    shift_d = shift_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    tx_wr   = 1'b0;
    tx_data = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (v0 | v1) begin
          ack0_d  = ~sel1;
          ack1_d  = sel1;
          grant_d = sel1;
          last_d  = sel1;
          crc_d   = 8'h00;
          shift_d = sel_data;
          len_d   = sel_len;
          cnt_d   = sel_len;
          if ((sel_len == 4'd0) || ({1'b0, sel_len} > MAX_LEN_W)) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SYNC;
          end
        end
      end
      S_SYNC: begin
        tx_wr   = 1'b1;
        tx_data = 8'hD5;
        ret_d   = S_LEN;
        state_d = S_WAIT;
      end
      S_LEN: begin
        tx_wr   = 1'b1;
        tx_data = {4'h0, len_q};
        ret_d   = S_DATA;
        state_d = S_WAIT;
      end
      S_DATA: begin
        tx_wr   = 1'b1;
        tx_data = top_byte;
        crc_d   = crc8_byte(crc_q, top_byte);
        shift_d = shift_q << 8;
        cnt_d   = cnt_q - 4'd1;
        ret_d   = (cnt_d == 4'd0) ? S_CRC : S_DATA;
        state_d = S_WAIT;
      end
      S_CRC: begin
        tx_wr   = 1'b1;
        tx_data = crc_q;
        ret_d   = S_IDLE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          state_d = ret_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      shift_q <= '0;
      len_q   <= 4'd0;
      cnt_q   <= 4'd0;
      crc_q   <= 8'h00;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
    end
  end

  assign req0_ack = ack0_q;
  assign req1_ack = ack1_q;
  assign err_len  = err_q;
  assign grant    = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_s3g_tx_arbiter.sv
// Directed bench for s3g_tx_arbiter with a UART model that answers each
// tx_wr with a tx_done pulse about 100 cycles later.
module tb_s3g_tx_arbiter;

  localparam int ML  = 8;
  localparam int LAT = 100;

  logic            clk;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic [3:0]      req0_len, req1_len;
  logic [8*ML-1:0] req0_data, req1_data;
  logic            req0_ack, req1_ack;
  logic [7:0]      tx_data;
  logic            tx_wr;
  logic            tx_done;
  logic            busy, grant, err_len;

  s3g_tx_arbiter #(.MAX_LEN(ML)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_len   (req0_len),
    .req0_data  (req0_data),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_len   (req1_len),
    .req1_data  (req1_data),
    .req1_ack   (req1_ack),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_done    (tx_done),
    .busy       (busy),
    .grant      (grant),
    .err_len    (err_len)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor / UART model state
  logic [7:0] wr_q[$];
  int         ack_port_q[$];
  int         ack_time_q[$];
  int         fall_time_q[$];
  int         err_cnt = 0;
  int         overlap = 0;
  int         ncyc = 0;
  int         pend = 0;
  int         done_ncyc = -10;
  logic       busy_prev = 1'b0;
  logic       spur = 1'b0;

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (tx_wr) begin
        if (pend > 0) overlap++;
        wr_q.push_back(tx_data);
        if (!(req0_ack | req1_ack)) check("wr_lat", 32'(ncyc), 32'(done_ncyc + 1));
        pend = LAT;
      end
      if (req0_ack | req1_ack) begin
        ack_port_q.push_back(req1_ack ? 1 : 0);
        ack_time_q.push_back(ncyc);
        check("ack_wr_busy", 32'({tx_wr, busy}), err_len ? 32'd0 : 32'd3);
      end
      if (err_len) err_cnt++;
      if (rst_n && busy_prev && !busy) begin
        fall_time_q.push_back(ncyc);
        check("busy_drop", 32'(ncyc), 32'(done_ncyc + 1));
      end
      busy_prev = busy;
      tx_done = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else if (spur) begin
        spur      = 1'b0;
        tx_done   = 1'b1;
        done_ncyc = ncyc;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_done   = 1'b1;
          done_ncyc = ncyc;
        end
      end
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    ack_port_q.delete();
    ack_time_q.delete();
    fall_time_q.delete();
    err_cnt = 0;
    overlap = 0;
  endtask

  task automatic set_req(input int port, input logic v, input logic [3:0] len, input logic [8*ML-1:0] data);
    if (port == 0) begin
      req0_valid = v; req0_len = len; req0_data = data;
    end else begin
      req1_valid = v; req1_len = len; req1_data = data;
    end
  endtask

  // Hold valid for n_frames grants, then drop it and scramble the data.
  task automatic drive_req(input int port, input logic [3:0] len, input logic [8*ML-1:0] data,
                           input int n_frames);
    int t;
    set_req(port, 1'b1, len, data);
    for (int f = 0; f < n_frames; f++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!((port == 0) ? req0_ack : req1_ack) && t < 20000);
      if (t >= 20000) check("ack_timeout", 32'(port), 32'hFFFF);
    end
    set_req(port, 1'b0, ~len, ~data);
  endtask

  task automatic wait_frame(input int n);
    int t;
    t = 0;
    while (!(wr_q.size() >= n && !busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) check("frame_timeout", 32'(wr_q.size()), 32'(n));
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    int n;
    check({tag, "_count"}, 32'(wr_q.size()), 32'(exp.size()));
    n = (wr_q.size() < exp.size()) ? wr_q.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_b%0d", tag, i), 32'(wr_q[i]), 32'(exp[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_tx_wr"},   32'(tx_wr),   32'h0);
    check({tag, "_ack0"},    32'(req0_ack), 32'h0);
    check({tag, "_ack1"},    32'(req1_ack), 32'h0);
    check({tag, "_err_len"}, 32'(err_len), 32'h0);
    check({tag, "_busy"},    32'(busy),    32'h0);
    check({tag, "_grant"},   32'(grant),   32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [8*ML-1:0] D81    = 64'h81FF_FFFF_FFFF_FFFF;
  localparam logic [8*ML-1:0] D5_PKT = 64'h5000_0000_8000_0000;
  localparam logic [8*ML-1:0] D3_PKT = 64'h81BA_CE00_0000_0000;

  logic [7:0] exp_q[$];

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, 4'd0, '0);
    set_req(1, 1'b0, 4'd0, '0);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // port 0, len 1, 0x81
    clear_logs();
    drive_req(0, 4'd1, D81, 1);
    wait_frame(4);
    exp_q = '{8'hD5, 8'h01, 8'h81, 8'hD2};
    check_bytes("p0_len1", exp_q);
    check("p0_len1_acks", 32'(ack_port_q.size()), 32'd1);
    if (ack_port_q.size() > 0) check("p0_len1_ackport", 32'(ack_port_q[0]), 32'd0);
    check("p0_len1_busy", 32'(busy), 32'd0);
    check("p0_len1_overlap", 32'(overlap), 32'd0);

    // port 1, len 5
    clear_logs();
    drive_req(1, 4'd5, D5_PKT, 1);
    wait_frame(8);
    exp_q = '{8'hD5, 8'h05, 8'h50, 8'h00, 8'h00, 8'h00, 8'h80, 8'h19};
    check_bytes("p1_len5", exp_q);
    check("p1_len5_grant", 32'(grant), 32'd1);

    // tie right after reset: port 0 first, then port 1
    pulse_reset();
    clear_logs();
    fork
      drive_req(0, 4'd3, D3_PKT, 1);
      drive_req(1, 4'd1, D81, 1);
    join
    wait_frame(10);
    exp_q = '{8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9, 8'hD5, 8'h01, 8'h81, 8'hD2};
    check_bytes("tie", exp_q);
    check("tie_acks", 32'(ack_port_q.size()), 32'd2);
    if (ack_port_q.size() == 2 && fall_time_q.size() >= 1) begin
      check("tie_order", 32'(ack_port_q[0] * 2 + ack_port_q[1]), 32'd1);
      check("tie_ack1_time", 32'(ack_time_q[1]), 32'(fall_time_q[0] + 1));
    end

    // both held valid for 4 frames
    clear_logs();
    fork
      drive_req(0, 4'd3, D3_PKT, 2);
      drive_req(1, 4'd5, D5_PKT, 2);
    join
    wait_frame(28);
    exp_q = '{8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9,
              8'hD5, 8'h05, 8'h50, 8'h00, 8'h00, 8'h00, 8'h80, 8'h19,
              8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9,
              8'hD5, 8'h05, 8'h50, 8'h00, 8'h00, 8'h00, 8'h80, 8'h19};
    check_bytes("rr4", exp_q);
    check("rr4_acks", 32'(ack_port_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_port_q.size(); i++)
      check($sformatf("rr4_grant%0d", i), 32'(ack_port_q[i]), 32'(i % 2));
    check("rr4_overlap", 32'(overlap), 32'd0);

    // illegal lengths
    clear_logs();
    drive_req(0, 4'd0, D81, 1);
    drive_req(1, 4'd9, D5_PKT, 1);
    repeat (5) @(negedge clk);
    check("err_count", 32'(err_cnt), 32'd2);
    check("err_acks", 32'(ack_port_q.size()), 32'd2);
    check("err_wr", 32'(wr_q.size()), 32'd0);
    check("err_busy", 32'(busy), 32'd0);

    // spurious tx_done in IDLE
    clear_logs();
    spur = 1'b1;
    repeat (5) @(negedge clk);
    check("spur_wr", 32'(wr_q.size()), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);

    // reset during DATA of a len-5 frame
    drive_req(1, 4'd5, D5_PKT, 1);
    begin
      int t;
      t = 0;
      while (wr_q.size() < 4 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) check("midrst_timeout", 32'(wr_q.size()), 32'd4);
    end
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_wr", 32'(wr_q.size()), 32'd4);
    check("midrst_acks", 32'(ack_port_q.size()), 32'd1);
    drive_req(0, 4'd3, D3_PKT, 1);
    wait_frame(10);
    exp_q = '{8'hD5, 8'h05, 8'h50, 8'h00, 8'hD5, 8'h03, 8'h81, 8'hBA, 8'hCE, 8'hF9};
    check_bytes("postrst", exp_q);
    check("postrst_grant", 32'(grant), 32'd0);
    check("postrst_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
